// File: rtl/mem_access_if.sv
// Bundles the start/result handshake and the data-memory req/ack bus of the
// memory access stage. The slave view is the stage itself; the master view is its environment.
interface mem_access_if;
  logic        start;
  logic [31:0] ins_mem;
  logic [31:0] ALU_result;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        wb_en;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  start, ins_mem, ALU_result, store_data, mem_ack, mem_rdata,
    output busy, done, load_data, wb_en, err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output start, ins_mem, ALU_result, store_data, mem_ack, mem_rdata,
    input  busy, done, load_data, wb_en, err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory stage: decodes the load/store opcode, runs one req/ack bus
// transaction and returns an extended load value or the ALU pass-through.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic [1:0]    lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          wb_en_q, wb_en_d;
  logic          err_q, err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic [5:0]    op_in;
  logic          in_load, in_store, in_misal;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext_data;
  logic [CW-1:0] cnt_inc;

  // Only the opcode field of the instruction matters to this stage.
  logic unused_ins;
  assign unused_ins = ^bus.ins_mem[25:0];

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lo_d        = lo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    wb_en_d     = wb_en_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    op_in    = bus.ins_mem[31:26];
    in_load  = is_load(op_in);
    in_store = is_store(op_in);
    in_misal = ((op_in == OP_LW || op_in == OP_SW) && bus.ALU_result[1:0] != 2'b00) ||
               ((op_in inside {OP_LH, OP_LHU, OP_SH}) && bus.ALU_result[0]);
    cnt_inc  = cnt_q + CW'(1);

    // Load extension works on the latched opcode/offset and the live read data.
    case (lo_q)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    half_sel = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (op_q)
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'd0, byte_sel};
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'd0, half_sel};
      default: ext_data = bus.mem_rdata;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = op_in;
          lo_d   = bus.ALU_result[1:0];
          cnt_d  = '0;
          busy_d = 1'b1;
          if (!(in_load || in_store)) begin
            state_d     = S_RESP;
            load_data_d = bus.ALU_result;
            wb_en_d     = 1'b1;
            err_d       = 1'b0;
          end else if (in_misal) begin
            state_d     = S_RESP;
            load_data_d = 32'd0;
            wb_en_d     = 1'b0;
            err_d       = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = in_store;
            mem_addr_d  = {bus.ALU_result[31:2], 2'b00};
            mem_be_d    = 4'hF;
            mem_wdata_d = 32'd0;
            if (op_in == OP_SB) begin
              mem_be_d    = 4'b0001 << bus.ALU_result[1:0];
              mem_wdata_d = {4{bus.store_data[7:0]}};
            end else if (op_in == OP_SH) begin
              mem_be_d    = bus.ALU_result[1] ? 4'b1100 : 4'b0011;
              mem_wdata_d = {2{bus.store_data[15:0]}};
            end else if (op_in == OP_SW) begin
              mem_wdata_d = bus.store_data;
            end
          end
        end
      end
      S_REQ: begin
        // An ack on the terminal-count cycle still wins over the abort.
        if (bus.mem_ack) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          wb_en_d     = is_load(op_q);
          err_d       = 1'b0;
          load_data_d = is_load(op_q) ? ext_data : 32'd0;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          cnt_d       = cnt_inc;
          wb_en_d     = 1'b0;
          err_d       = 1'b1;
          load_data_d = 32'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 6'd0;
      lo_q        <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= 32'd0;
      wb_en_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      wb_en_q     <= wb_en_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.load_data = load_data_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
